aexm_regf_mt: RTL and testbench

AEXM_REGF_MT -- requirements
Module: aexm_regf_mt

---
 rtl/aexm_regf_pkg.sv | 25 ++
 rtl/aexm_regf_sizer.sv | 75 +++++++
 rtl/aexm_regf_mt.sv | 125 ++++++++++++
 tb/tb_aexm_regf_mt.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/aexm_regf_pkg.sv
// Shared encodings for the multi-threaded register file: writeback select,
// store size, load lane-select codes and the clear/run state type.
package aexm_regf_pkg;

  localparam logic [1:0] MxResult = 2'd0;
  localparam logic [1:0] MxLink   = 2'd1;
  localparam logic [1:0] MxLoad   = 2'd2;
  localparam logic [1:0] MxNone   = 2'd3;

  localparam logic [1:0] OpcByte = 2'd0;
  localparam logic [1:0] OpcHalf = 2'd1;
  localparam logic [1:0] OpcWord = 2'd2;
  localparam logic [1:0] OpcNone = 2'd3;

  localparam logic [3:0] DwbB3   = 4'h8;
  localparam logic [3:0] DwbB2   = 4'h4;
  localparam logic [3:0] DwbB1   = 4'h2;
  localparam logic [3:0] DwbB0   = 4'h1;
  localparam logic [3:0] DwbHHi  = 4'hC;
  localparam logic [3:0] DwbHLo  = 4'h3;
  localparam logic [3:0] DwbWord = 4'hF;

  typedef enum logic {StClr, StRun} state_e;

endpackage

// File: rtl/aexm_regf_sizer.sv
// Combinational load lane extractor and store data replicator / byte-enable generator.
// Sign extension of sub-word loads is built only when AEXM_REGF_SEXT_EN is defined.
module aexm_regf_sizer
  import aexm_regf_pkg::*;
(
  input  logic [3:0]  dwbsel_i,
  input  logic        sign_i,
  input  logic [31:0] datai_i,
  input  logic [1:0]  opc_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] xdst_i,
  output logic [31:0] dwbdi_o,
  output logic [31:0] datao_o,
  output logic [3:0]  wsel_o
);

  logic sext;
`ifdef AEXM_REGF_SEXT_EN
  assign sext = sign_i;
`else
  logic unused_sign;
  assign unused_sign = sign_i;
  assign sext = 1'b0;
`endif

  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    dwbdi_o = 32'h0;
    lb      = 8'h0;
    lh      = 16'h0;
    unique case (dwbsel_i)
      DwbB3, DwbB2, DwbB1, DwbB0: begin
        unique case (dwbsel_i)
          DwbB3:   lb = datai_i[31:24];
          DwbB2:   lb = datai_i[23:16];
          DwbB1:   lb = datai_i[15:8];
          default: lb = datai_i[7:0];
        endcase
        dwbdi_o = {{24{sext & lb[7]}}, lb};
      end
      DwbHHi, DwbHLo: begin
        lh      = (dwbsel_i == DwbHHi) ? datai_i[31:16] : datai_i[15:0];
        dwbdi_o = {{16{sext & lh[15]}}, lh};
      end
      DwbWord: dwbdi_o = datai_i;
      default: dwbdi_o = 32'h0;
    endcase
  end

  always_comb begin
    datao_o = 32'h0;
    wsel_o  = 4'h0;
    unique case (opc_i)
      OpcByte: begin
        datao_o = {4{xdst_i[7:0]}};
        wsel_o  = 4'b1000 >> addr_i;
      end
      OpcHalf: begin
        datao_o = {2{xdst_i[15:0]}};
        wsel_o  = addr_i[1] ? 4'b0011 : 4'b1100;
      end
      OpcWord: begin
        datao_o = xdst_i;
        wsel_o  = 4'b1111;
      end
      default: begin
        datao_o = 32'h0;
        wsel_o  = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/aexm_regf_mt.sv
// Banked per-thread register file with power-on clear sweep, write forwarding
// and load/store sizing. Optional sign-extended loads: AEXM_REGF_SEXT_EN.
module aexm_regf_mt
  import aexm_regf_pkg::*;
#(
  parameter int unsigned NTHR = 2,
  parameter int unsigned NREG = 32,
  localparam int unsigned AW = $clog2(NREG),
  localparam int unsigned TW = (NTHR > 1) ? $clog2(NTHR) : 1
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          x_en,
  input  logic [TW-1:0] rTHR,
  input  logic [AW-1:0] rRA,
  input  logic [AW-1:0] rRB,
  input  logic [AW-1:0] rRD,
  input  logic [TW-1:0] rWTHR,
  input  logic [AW-1:0] rRW,
  input  logic [1:0]    rMXDST,
  input  logic [29:0]   rPCLNK,
  input  logic [31:0]   rRESULT,
  input  logic [3:0]    rDWBSEL,
  input  logic          rSIGN,
  input  logic [1:0]    rOPC,
  input  logic [1:0]    rADDR,
  input  logic [31:0]   aexm_dcache_datai,
  output logic [31:0]   rREGA,
  output logic [31:0]   rREGB,
  output logic [31:0]   rDWBDI,
  output logic [31:0]   aexm_dcache_datao,
  output logic [3:0]    aexm_dcache_wsel,
  output logic          rBUSY
);

  localparam int unsigned Depth = NTHR * NREG;
  localparam int unsigned IW    = $clog2(Depth);

  // Thread bits are dropped for a single-bank build so the index stays in range.
  function automatic logic [IW-1:0] idx(input logic [TW-1:0] t, input logic [AW-1:0] r);
    logic [TW-1:0] te;
    te = (NTHR > 1) ? t : {TW{1'b0}};
    return IW'({te, r});
  endfunction

  logic [31:0]   mem_q [Depth];
  state_e        state_q;
  logic [IW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   rega_q, regb_q;

  logic        wr_en, wr_tmatch;
  logic [31:0] wr_data, rd_a, rd_b, rd_d, xdst;

  always_comb begin
    wr_en     = (state_q == StRun) && x_en && (rRW != '0) && (rMXDST != MxNone);
    wr_tmatch = (rWTHR == rTHR);
    unique case (rMXDST)
      MxResult: wr_data = rRESULT;
      MxLink:   wr_data = {rPCLNK, 2'b00};
      MxLoad:   wr_data = rDWBDI;
      default:  wr_data = 32'h0;
    endcase
    rd_a = (rRA == '0) ? 32'h0 : mem_q[idx(rTHR, rRA)];
    rd_b = (rRB == '0) ? 32'h0 : mem_q[idx(rTHR, rRB)];
    rd_d = (rRD == '0) ? 32'h0 : mem_q[idx(rTHR, rRD)];
    if (rMXDST == MxLoad && wr_tmatch && rRW == rRD) begin
      xdst = rDWBDI;
    end else if (rMXDST == MxResult && wr_tmatch && rRW == rRD) begin
      xdst = rRESULT;
    end else begin
      xdst = rd_d;
    end
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state_q <= StClr;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == StClr) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == IW'(Depth - 1)) begin
        state_q <= StRun;
        busy_q  <= 1'b0;
      end
    end
  end

  // Storage itself needs no reset: the sweep clears it after every reset.
  always_ff @(posedge gclk) begin
    if (state_q == StClr) begin
      mem_q[cnt_q] <= 32'h0;
    end else if (wr_en) begin
      mem_q[idx(rWTHR, rRW)] <= wr_data;
    end
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      rega_q <= 32'h0;
      regb_q <= 32'h0;
    end else if (x_en) begin
      rega_q <= (wr_en && wr_tmatch && rRW == rRA) ? wr_data : rd_a;
      regb_q <= (wr_en && wr_tmatch && rRW == rRB) ? wr_data : rd_b;
    end
  end

  assign rREGA = rega_q;
  assign rREGB = regb_q;
  assign rBUSY = busy_q;

  aexm_regf_sizer u_sizer (
    .dwbsel_i (rDWBSEL),
    .sign_i   (rSIGN),
    .datai_i  (aexm_dcache_datai),
    .opc_i    (rOPC),
    .addr_i   (rADDR),
    .xdst_i   (xdst),
    .dwbdi_o  (rDWBDI),
    .datao_o  (aexm_dcache_datao),
    .wsel_o   (aexm_dcache_wsel)
  );

endmodule

// File: tb/tb_aexm_regf_mt.sv
// Directed bench for aexm_regf_mt (NTHR=2, NREG=32); honours AEXM_REGF_SEXT_EN.
module tb_aexm_regf_mt;

  logic        gclk = 1'b0;
  logic        grst;
  logic        x_en;
  logic [0:0]  rTHR, rWTHR;
  logic [4:0]  rRA, rRB, rRD, rRW;
  logic [1:0]  rMXDST, rOPC, rADDR;
  logic [29:0] rPCLNK;
  logic [31:0] rRESULT, datai;
  logic [3:0]  rDWBSEL;
  logic        rSIGN;
  logic [31:0] rREGA, rREGB, rDWBDI, datao;
  logic [3:0]  wsel;
  logic        rBUSY;

  int ncmp = 0;
  int nerr = 0;
  int n;

  always #5 gclk = ~gclk;

  aexm_regf_mt #(.NTHR(2), .NREG(32)) dut (
    .gclk              (gclk),
    .grst              (grst),
    .x_en              (x_en),
    .rTHR              (rTHR),
    .rRA               (rRA),
    .rRB               (rRB),
    .rRD               (rRD),
    .rWTHR             (rWTHR),
    .rRW               (rRW),
    .rMXDST            (rMXDST),
    .rPCLNK            (rPCLNK),
    .rRESULT           (rRESULT),
    .rDWBSEL           (rDWBSEL),
    .rSIGN             (rSIGN),
    .rOPC              (rOPC),
    .rADDR             (rADDR),
    .aexm_dcache_datai (datai),
    .rREGA             (rREGA),
    .rREGB             (rREGB),
    .rDWBDI            (rDWBDI),
    .aexm_dcache_datao (datao),
    .aexm_dcache_wsel  (wsel),
    .rBUSY             (rBUSY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  // Counts cycles until rBUSY drops, bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (rBUSY === 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    grst = 1'b0; x_en = 1'b0; rTHR = '0; rWTHR = '0;
    rRA = '0; rRB = '0; rRD = '0; rRW = '0;
    rMXDST = 2'd3; rOPC = 2'd3; rADDR = '0; rPCLNK = '0; rRESULT = '0;
    datai = '0; rDWBSEL = '0; rSIGN = 1'b0;
    step(); step();
    check("rst_busy", {31'b0, rBUSY}, 32'd1);
    check("rst_rega", rREGA, 32'h0);
    check("rst_regb", rREGB, 32'h0);

    // Initial sweep length
    grst = 1'b1;
    count_busy(n);
    check("sweep_len", n, 32'd64);

    // Every register reads zero after the sweep
    x_en = 1'b1;
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < 32; r++) begin
        rTHR = t[0:0]; rRA = r[4:0]; rRB = 5'(31 - r);
        step();
        check("clr_rega", rREGA, 32'h0);
        check("clr_regb", rREGB, 32'h0);
      end
    end
    check("run_busy", {31'b0, rBUSY}, 32'd0);

    // Same-cycle write forwarding, thread isolation
    rMXDST = 2'd0; rRESULT = 32'h12345678; rWTHR = 1'b1; rRW = 5'd5;
    rTHR = 1'b1; rRA = 5'd5; rRB = 5'd0;
    step();
    check("fwd_rega", rREGA, 32'h12345678);
    check("fwd_regb_r0", rREGB, 32'h0);
    rMXDST = 2'd3; rTHR = 1'b0;
    step();
    check("thr0_r5", rREGA, 32'h0);
    rTHR = 1'b1;
    step();
    check("thr1_r5", rREGA, 32'h12345678);
    x_en = 1'b0; rRA = 5'd0;
    step();
    check("hold_rega", rREGA, 32'h12345678);

    // Link writeback and r0 protection
    x_en = 1'b1; rMXDST = 2'd1; rPCLNK = 30'h400; rWTHR = 1'b0; rRW = 5'd3;
    rTHR = 1'b0; rRA = 5'd0; rRB = 5'd3;
    step();
    check("link_fwd", rREGB, 32'h00001000);
    rRW = 5'd0; rRA = 5'd0;
    step();
    check("r0_fwd", rREGA, 32'h0);
    rMXDST = 2'd3;
    step();
    check("r0_mem", rREGA, 32'h0);
    check("r3_mem", rREGB, 32'h00001000);
    x_en = 1'b0;

    // Load sizer
    datai = 32'h80FF7F01; rSIGN = 1'b1;
`ifdef AEXM_REGF_SEXT_EN
    rDWBSEL = 4'h8; #1; check("ld_b3_s", rDWBDI, 32'hFFFFFF80);
    rDWBSEL = 4'h4; #1; check("ld_b2_s", rDWBDI, 32'hFFFFFFFF);
    rDWBSEL = 4'hC; #1; check("ld_hhi_s", rDWBDI, 32'hFFFF80FF);
`else
    rDWBSEL = 4'h8; #1; check("ld_b3_s", rDWBDI, 32'h00000080);
    rDWBSEL = 4'h4; #1; check("ld_b2_s", rDWBDI, 32'h000000FF);
    rDWBSEL = 4'hC; #1; check("ld_hhi_s", rDWBDI, 32'h000080FF);
`endif
    rDWBSEL = 4'h2; #1; check("ld_b1", rDWBDI, 32'h0000007F);
    rDWBSEL = 4'h3; #1; check("ld_hlo", rDWBDI, 32'h00007F01);
    rDWBSEL = 4'h5; #1; check("ld_bad", rDWBDI, 32'h0);
    rSIGN = 1'b0;
    rDWBSEL = 4'h8; #1; check("ld_b3_z", rDWBDI, 32'h00000080);
    rDWBSEL = 4'h1; #1; check("ld_b0", rDWBDI, 32'h00000001);
    rDWBSEL = 4'hF; #1; check("ld_word", rDWBDI, 32'h80FF7F01);

    // Store sizer
    rOPC = 2'd0; rADDR = 2'd2; rRD = 5'd7; rRW = 5'd7; rTHR = 1'b0; rWTHR = 1'b0;
    rMXDST = 2'd0; rRESULT = 32'h000000AB;
    #1; check("st_b_data", datao, 32'hABABABAB); check("st_b_wsel", {28'b0, wsel}, 32'h2);
    rADDR = 2'd0; #1; check("st_b0_wsel", {28'b0, wsel}, 32'h8);
    rOPC = 2'd1; rRESULT = 32'h00001234;
    #1; check("st_h_data", datao, 32'h12341234); check("st_h_wsel", {28'b0, wsel}, 32'hC);
    rADDR = 2'd2; #1; check("st_h2_wsel", {28'b0, wsel}, 32'h3);
    rOPC = 2'd2; #1; check("st_w_data", datao, 32'h00001234);
    check("st_w_wsel", {28'b0, wsel}, 32'hF);
    rMXDST = 2'd2; #1; check("st_load_src", datao, 32'h80FF7F01);
    rMXDST = 2'd3; rTHR = 1'b1; rRD = 5'd5; #1; check("st_mem_src", datao, 32'h12345678);
    rOPC = 2'd3; #1; check("st_none_data", datao, 32'h0);
    check("st_none_wsel", {28'b0, wsel}, 32'h0);

    // Reset in RUN, then reset again mid-sweep
    grst = 1'b0; #1;
    check("rrst_busy", {31'b0, rBUSY}, 32'd1);
    check("rrst_rega", rREGA, 32'h0);
    step();
    grst = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("mid_busy", {31'b0, rBUSY}, 32'd1);
    grst = 1'b0;
    step();
    grst = 1'b1;
    // Writes to an already-cleared entry during the sweep must be dropped
    x_en = 1'b1; rMXDST = 2'd0; rRESULT = 32'hDEADBEEF; rWTHR = 1'b0; rRW = 5'd1;
    rTHR = 1'b0; rRA = 5'd2; rRB = 5'd2;
    count_busy(n);
    rMXDST = 2'd3;
    check("resweep_len", n, 32'd64);
    rTHR = 1'b0; rRA = 5'd1; rRB = 5'd3;
    step();
    check("clr_wr_ign", rREGA, 32'h0);
    check("r3_recleared", rREGB, 32'h0);
    rTHR = 1'b1; rRA = 5'd5;
    step();
    check("t1r5_recleared", rREGA, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
